// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: FSM state encodings,
// byte-lane count and the word-alignment test.
package load_store_unit_pkg;

  typedef logic [1:0] lsu_state_t;

  localparam lsu_state_t ST_IDLE = 2'b00;
  localparam lsu_state_t ST_REQ  = 2'b01;
  localparam lsu_state_t ST_DONE = 2'b10;

  localparam int BYTE_LANES = 4;

  function automatic logic is_misaligned(input logic byte_acc, input logic [1:0] addr_lo);
    return !byte_acc && (addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/load_store_unit_lane.sv
// Byte-lane steering: store byte replication, byte enables and
// little-endian load lane extraction with zero extension.
module lsu_lane
  import load_store_unit_pkg::*;
(
  input  logic [1:0]              i_lane,
  input  logic                    i_byte,
  input  logic [8*BYTE_LANES-1:0] i_wdata,
  input  logic [8*BYTE_LANES-1:0] i_rdata,
  output logic [BYTE_LANES-1:0]   o_be,
  output logic [8*BYTE_LANES-1:0] o_wdata,
  output logic [8*BYTE_LANES-1:0] o_rdata
);

  logic [7:0] w_lanes [BYTE_LANES];

  genvar gi;
  generate
    for (gi = 0; gi < BYTE_LANES; gi++) begin : g_lane
      assign o_be[gi]            = !i_byte || (i_lane == 2'(gi));
      assign o_wdata[8*gi +: 8]  = i_byte ? i_wdata[7:0] : i_wdata[8*gi +: 8];
      assign w_lanes[gi]         = i_rdata[8*gi +: 8];
    end
  endgenerate

  assign o_rdata = i_byte ? {24'h0, w_lanes[i_lane]} : i_rdata;

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: IDLE -> REQ -> DONE access FSM with wait timeout.
// Optional macro LSU_ALIGN_CHECK_EN faults misaligned word accesses without a bus cycle.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReqM,
  input  logic        MLoadM,
  input  logic        MByteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadData,
  output logic        StallM,
  output logic        BusError,
  load_store_unit_if.master mem
);

  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  lsu_state_t        r_state;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic              r_load;
  logic              r_byte;
  logic [WAIT_W-1:0] r_wait;
  logic [31:0]       r_read_data;
  logic              r_bus_err;

  logic              w_in_idle;
  logic              w_in_req;
  logic              w_align_fault;
  logic [3:0]        w_be;
  logic [31:0]       w_lane_wdata;
  logic [31:0]       w_load_data;

  assign w_in_idle = (r_state == ST_IDLE);
  assign w_in_req  = (r_state == ST_REQ);

`ifdef LSU_ALIGN_CHECK_EN
  assign w_align_fault = is_misaligned(MByteM, ALUOutM[1:0]);
`else
  assign w_align_fault = 1'b0;
`endif

  lsu_lane u_lane (
    .i_lane  (r_addr[1:0]),
    .i_byte  (r_byte),
    .i_wdata (r_wdata),
    .i_rdata (mem.mem_rdata),
    .o_be    (w_be),
    .o_wdata (w_lane_wdata),
    .o_rdata (w_load_data)
  );

  // Access attributes are captured once so the pipeline may change them while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_load  <= 1'b0;
      r_byte  <= 1'b0;
    end else if (w_in_idle && MemReqM) begin
      r_addr  <= ALUOutM;
      r_wdata <= WriteDataM;
      r_load  <= MLoadM;
      r_byte  <= MByteM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_wait      <= '0;
      r_read_data <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (MemReqM) begin
            r_wait <= '0;
            if (w_align_fault) begin
              r_state   <= ST_DONE;
              r_bus_err <= 1'b1;
              if (MLoadM) r_read_data <= '0;
            end else begin
              r_state <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          // A ready on the last permitted cycle still completes normally.
          if (mem.mem_ready) begin
            if (r_load) r_read_data <= w_load_data;
            r_state <= ST_DONE;
          end else if (r_wait == WAIT_LAST) begin
            r_bus_err   <= 1'b1;
            r_read_data <= '0;
            r_state     <= ST_DONE;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign StallM   = (w_in_idle && MemReqM) || w_in_req;
  assign ReadData = r_read_data;
  assign BusError = r_bus_err;

  assign mem.mem_req   = w_in_req;
  assign mem.mem_we    = w_in_req && !r_load;
  assign mem.mem_addr  = w_in_req ? {r_addr[31:2], 2'b00} : 32'h0;
  assign mem.mem_be    = w_in_req ? w_be : 4'h0;
  assign mem.mem_wdata = w_in_req ? w_lane_wdata : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random accesses
// against a transaction-level model of latency, lanes and ReadData.
module tb_load_store_unit;

  localparam int MAX_WAIT = 16;
`ifdef LSU_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReqM, MLoadM, MByteM;
  logic [31:0] ALUOutM, WriteDataM;
  logic [31:0] ReadData;
  logic        StallM, BusError;

  load_store_unit_if mem_bus ();

  load_store_unit #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReqM    (MemReqM),
    .MLoadM     (MLoadM),
    .MByteM     (MByteM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .ReadData   (ReadData),
    .StallM     (StallM),
    .BusError   (BusError),
    .mem        (mem_bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access; the bench plays memory, raising ready after 'delay' REQ cycles.
  task automatic access(input bit ld, input bit by, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int delay, input string tag);
    bit   skip, tmo;
    int   n_req;
    int   lane;
    lane  = int'(addr[1:0]);
    skip  = ALIGN_EN && !by && (lane != 0);
    tmo   = !skip && (delay >= MAX_WAIT);
    n_req = skip ? 0 : (tmo ? MAX_WAIT : delay + 1);

    MemReqM = 1'b1; MLoadM = ld; MByteM = by; ALUOutM = addr; WriteDataM = wd;
    mem_bus.mem_ready = 1'b0;
    #1;
    chk({tag, " idle_stall"}, StallM, 1);
    chk({tag, " idle_req"}, mem_bus.mem_req, 0);
    @(posedge clk); @(negedge clk);
    MemReqM = 1'b0; ALUOutM = $urandom; WriteDataM = $urandom;
    MLoadM = 1'($urandom); MByteM = 1'($urandom);

    for (int c = 0; c < n_req; c++) begin
      chk({tag, " req"}, mem_bus.mem_req, 1);
      chk({tag, " req_stall"}, StallM, 1);
      chk({tag, " addr"}, mem_bus.mem_addr, addr & 32'hFFFF_FFFC);
      chk({tag, " we"}, mem_bus.mem_we, !ld);
      if (!ld) begin
        chk({tag, " be"}, mem_bus.mem_be, by ? (32'd1 << lane) : 32'hF);
        chk({tag, " wdata"}, mem_bus.mem_wdata, by ? wd[7:0] * 32'h0101_0101 : wd);
      end
      if (!tmo && c == delay) begin
        mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = rd;
      end else begin
        mem_bus.mem_ready = 1'b0; mem_bus.mem_rdata = $urandom;
      end
      @(posedge clk); @(negedge clk);
      mem_bus.mem_ready = 1'b0;
    end

    if (skip || tmo) begin
      if (ld || tmo) exp_rd = 32'h0;
    end else if (ld) begin
      exp_rd = by ? ((rd >> (8 * lane)) & 32'hFF) : rd;
    end

    chk({tag, " done_stall"}, StallM, 0);
    chk({tag, " done_req"}, mem_bus.mem_req, 0);
    chk({tag, " done_we"}, mem_bus.mem_we, 0);
    chk({tag, " done_buserr"}, BusError, skip || tmo);
    chk({tag, " done_rdata"}, ReadData, exp_rd);
    @(posedge clk); @(negedge clk);
    chk({tag, " idle_buserr"}, BusError, 0);
    chk({tag, " idle_stall2"}, StallM, 0);
    chk({tag, " idle_req2"}, mem_bus.mem_req, 0);
    chk({tag, " idle_rdata"}, ReadData, exp_rd);
    $display("txn %s ld=%0d byte=%0d addr=%h wd=%h rd=%h delay=%0d ReadData=%h BusError_exp=%0d",
             tag, ld, by, addr, wd, rd, delay, ReadData, skip || tmo);
  endtask

  initial begin
    reset = 1'b1; MemReqM = 1'b0; MLoadM = 1'b0; MByteM = 1'b0;
    ALUOutM = '0; WriteDataM = '0;
    mem_bus.mem_ready = 1'b0; mem_bus.mem_rdata = '0;
    exp_rd = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst rdata", ReadData, 0);
    chk("rst buserr", BusError, 0);
    chk("rst req", mem_bus.mem_req, 0);
    chk("rst stall", StallM, 0);

    repeat (2) begin
      @(posedge clk); @(negedge clk);
      chk("idle req", mem_bus.mem_req, 0);
      chk("idle we", mem_bus.mem_we, 0);
      chk("idle stall", StallM, 0);
    end

    access(1'b0, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, "word_store");
    access(1'b1, 1'b1, 32'h0000_0103, 32'h0, 32'hAABB_CCDD, 0, "byte_load");
    access(1'b0, 1'b1, 32'h0000_0201, 32'h1234_5678, 32'h0, 2, "byte_store");
    access(1'b1, 1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, MAX_WAIT - 1, "ready_last");
    access(1'b1, 1'b0, 32'h0000_0304, 32'h0, 32'h1111_2222, 100, "timeout");
    access(1'b1, 1'b0, 32'h0000_0308, 32'h0, 32'h5A5A_A5A5, 1, "word_load");
    access(1'b1, 1'b0, 32'h0000_0102, 32'h0, 32'h7777_8888, 0, "misaligned_load");

    // Reset in REQ with ready high: the access is abandoned and ReadData cleared.
    MemReqM = 1'b1; MLoadM = 1'b1; MByteM = 1'b0; ALUOutM = 32'h400;
    @(posedge clk); @(negedge clk);
    MemReqM = 1'b0;
    chk("midreq req", mem_bus.mem_req, 1);
    reset = 1'b1; mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'h9999_9999;
    @(posedge clk); @(negedge clk);
    reset = 1'b0; mem_bus.mem_ready = 1'b0;
    exp_rd = 32'h0;
    chk("midreq_rst req", mem_bus.mem_req, 0);
    chk("midreq_rst stall", StallM, 0);
    chk("midreq_rst rdata", ReadData, 0);
    chk("midreq_rst buserr", BusError, 0);
    access(1'b1, 1'b1, 32'h0000_0402, 32'h0, 32'h00C3_0000, 0, "after_rst");

    for (int i = 0; i < 40; i++) begin
      int d;
      d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(MAX_WAIT - 2, MAX_WAIT + 3))
                                       : int'($urandom_range(0, 3));
      access(1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, d, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter MAX_WAIT, default 16, giving the maximum REQ-state cycles before a bus-error abort.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port MemReqM, input, 1 bit: the memory-stage instruction performs a data access.
REQ-005 The block SHALL have port MLoadM, input, 1 bit: 1 = load, 0 = store.
REQ-006 The block SHALL have port MByteM, input, 1 bit: 1 = byte access, 0 = word access.
REQ-007 The block SHALL have port ALUOutM, input, 32 bits: byte address.
REQ-008 The block SHALL have port WriteDataM, input, 32 bits: store data.
REQ-009 The block SHALL have port ReadData, output, 32 bits: load result for the memory-to-writeback register.
REQ-010 The block SHALL have port StallM, output, 1 bit: freezes fetch through memory while an access is in flight.
REQ-011 The block SHALL have port BusError, output, 1 bit: one-cycle pulse on timeout or alignment fault.
REQ-012 The block SHALL have ports mem_req (1, output), mem_we (1, output), mem_addr (32, output, word-aligned), mem_be (4, output), mem_wdata (32, output), mem_ready (1, input) and mem_rdata (32, input).

Function
REQ-013 The FSM SHALL have states IDLE, REQ and DONE, encoded in 2 bits.
REQ-014 In IDLE with MemReqM=1, the block SHALL register the address, data, MLoadM and MByteM, go to REQ, and assert StallM combinationally.
REQ-015 In REQ, mem_req SHALL be 1; mem_addr SHALL be {addr[31:2],2'b00}; mem_we SHALL be !load.
REQ-016 For byte stores, mem_be SHALL be 1 shifted left by addr[1:0], and mem_wdata SHALL be the low byte replicated ×4.
REQ-017 For word stores, mem_be SHALL be 4'b1111 and mem_wdata SHALL be WriteDataM.
REQ-018 In REQ with mem_ready=1, the block SHALL capture the load data into ReadData and go to DONE; StallM SHALL remain 1 in REQ.
REQ-019 A byte load SHALL zero-extend lane addr[1:0] of mem_rdata (little-endian); a word load SHALL pass mem_rdata unchanged.
REQ-020 In DONE, StallM SHALL be 0 and the block SHALL go to IDLE next cycle unconditionally; minimum access latency is 3 cycles (IDLE, REQ, DONE).
REQ-021 ReadData SHALL hold its value until the next completed load; stores SHALL NOT change it.
REQ-022 A wait counter SHALL count REQ cycles with mem_ready=0. On reaching MAX_WAIT, the block SHALL drop mem_req, pulse BusError, set ReadData=0 and go to DONE.
REQ-023 mem_req SHALL be 0 in IDLE and DONE.
REQ-024 MemReqM=0 in IDLE SHALL leave all outputs idle with StallM=0.

Reset
REQ-025 On reset=1 at a clock edge, the block SHALL set: state IDLE, ReadData=0, counter=0, BusError=0, mem_req=0.
REQ-026 Reset SHALL have priority over mem_ready. A reset during REQ SHALL abandon the access with no DONE cycle.

Configuration
REQ-027 With LSU_ALIGN_CHECK_EN defined, a word access with addr[1:0]≠0 SHALL skip REQ: the block goes IDLE→DONE, pulses BusError, sets ReadData=0 for loads, and issues no memory write.
REQ-028 Without LSU_ALIGN_CHECK_EN, misaligned word accesses SHALL proceed with the address aligned down and BusError never asserted for alignment.

Structure
REQ-029 A shared package SHALL hold the FSM state typedef, the state encodings and a byte-lane constant (4).
REQ-030 A single sub-module, lsu_lane, SHALL perform byte-lane steering: store replication, byte enables and load extraction/zero-extend.

Verification
REQ-031 Word store, addr 0x100, data 0xDEADBEEF, ready on first REQ cycle -> mem_be=1111, mem_addr=0x100, StallM high 2 cycles.
REQ-032 Byte load, addr 0x103, mem_rdata=0xAABBCCDD -> ReadData=0x000000AA in DONE.
REQ-033 Byte store, addr 0x201, data 0x12345678 -> mem_be=0010, mem_wdata=0x78787878.
REQ-034 mem_ready held 0 with MAX_WAIT=16 -> BusError pulse after 16 REQ cycles, ReadData=0, return to IDLE.
REQ-035 Reset asserted mid-REQ -> next cycle state IDLE, mem_req=0, StallM=0.
REQ-036 With LSU_ALIGN_CHECK_EN, word load at 0x102 -> no mem_req, BusError=1, ReadData=0.
